// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU adder/subtractor, the result stage and the
// writeback stage: datapath width, destination tag width, result buffer
// depth and the packed condition-flag type.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int TAG_W = 3;
    localparam int DEPTH = 2;

    // Bit order {c, v, n, z}: c is bit 3, z is bit 0.
    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flag_t;

endpackage

// File: rtl/alu_flag_reg.sv
// alu_flag_reg
// Architectural condition-flag register. Loads d when we is high.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears q
//   we    - write enable
//   d     - next flags {c, v, n, z}
//   q     - current flags {c, v, n, z}
module alu_flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'b0000;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Two-entry in-order buffer between the adder/subtractor and writeback.
// Each entry holds the sum, destination tag, the four flags as supplied by
// the adder and a flag write enable. When an entry with flag_we set is
// popped, its flags are committed to the architectural flag register.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   in_valid / in_ready    - upstream handshake (in_ready is registered)
//   in_sum, in_tag         - result and destination tag
//   in_cout, in_overflow,
//   in_neg, in_zero        - flags from the adder/subtractor
//   in_flag_we             - entry updates flags when retired
//   flush                  - discard all buffered entries at the next edge
//   out_valid / out_ready  - downstream handshake
//   out_result, out_tag    - head entry
//   flag_c/v/n/z           - architectural flags
module alu_result_stage #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int TAG_W = alu_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_overflow,
    input  logic             in_neg,
    input  logic             in_zero,
    input  logic             in_flag_we,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z
);

    import alu_pkg::*;

    logic [WIDTH-1:0] r_sum   [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    flag_t            r_flags [DEPTH];
    logic             r_we    [DEPTH];

    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       r_in_ready;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;
    flag_t      w_in_flags;
    flag_t      w_flags_q;
    logic [3:0] w_flags_q_bits;

    assign w_in_flags = '{c: in_cout, v: in_overflow, n: in_neg, z: in_zero};

    // out_valid already masks flush, so a flush cycle can never pop.
    assign out_valid  = (r_count != 2'd0) && !flush;
    assign in_ready   = r_in_ready;
    assign out_result = r_sum[r_rptr];
    assign out_tag    = r_tag[r_rptr];

    assign w_push = in_valid && r_in_ready && !flush;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                r_sum[i]   <= '0;
                r_tag[i]   <= '0;
                r_flags[i] <= '0;
                r_we[i]    <= 1'b0;
            end
        end else begin
            r_count <= w_count_nxt;
            // Registered ready: derived from next count, so out_ready never
            // reaches in_ready combinationally.
            r_in_ready <= (w_count_nxt < 2'd2);
            if (flush) begin
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_sum[r_wptr]   <= in_sum;
                    r_tag[r_wptr]   <= in_tag;
                    r_flags[r_wptr] <= w_in_flags;
                    r_we[r_wptr]    <= in_flag_we;
                    r_wptr          <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
            end
        end
    end

    alu_flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_pop && r_we[r_rptr]),
        .d     (r_flags[r_rptr]),
        .q     (w_flags_q_bits)
    );

    assign w_flags_q = flag_t'(w_flags_q_bits);
    assign flag_c    = w_flags_q.c;
    assign flag_v    = w_flags_q.v;
    assign flag_n    = w_flags_q.n;
    assign flag_z    = w_flags_q.z;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
// Directed bench for alu_result_stage. Inputs change 1 time unit after a
// rising edge; outputs are sampled at that same point.
module tb_alu_result_stage;

    localparam int WIDTH = 16;
    localparam int TAG_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic             in_overflow;
    logic             in_neg;
    logic             in_zero;
    logic             in_flag_we;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;
    logic             flag_z;

    int n_tests = 0;
    int n_fail  = 0;

    alu_result_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_cout     (in_cout),
        .in_overflow (in_overflow),
        .in_neg      (in_neg),
        .in_zero     (in_zero),
        .in_flag_we  (in_flag_we),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .flag_n      (flag_n),
        .flag_z      (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one upstream result; flags given as {c,v,n,z}.
    task automatic drive(input logic v, input logic [15:0] sum, input logic [2:0] tag,
                         input logic [3:0] cvnz, input logic we);
        in_valid    = v;
        in_sum      = sum;
        in_tag      = tag;
        in_cout     = cvnz[3];
        in_overflow = cvnz[2];
        in_neg      = cvnz[1];
        in_zero     = cvnz[0];
        in_flag_we  = we;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        #12;
        check("rst_in_ready",   in_ready,   1);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag",    out_tag,    0);
        check("rst_flags",      {flag_c, flag_v, flag_n, flag_z}, 0);
        rst_n = 1'b1;
        tick();

        // Single pass: zero result with flag_we
        out_ready = 1'b1;
        drive(1'b1, 16'h0000, 3'd5, 4'b0001, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        check("sp_out_valid",  out_valid,  1);
        check("sp_out_result", out_result, 16'h0000);
        check("sp_out_tag",    out_tag,    5);
        check("sp_z_before",   flag_z,     0);
        tick();
        check("sp_z_after",    flag_z,     1);
        check("sp_empty",      out_valid,  0);

        // Back-pressure
        out_ready = 1'b0;
        drive(1'b1, 16'h1234, 3'd1, 4'b0000, 1'b0);
        tick();
        check("bp_ready_1",  in_ready,   1);
        check("bp_head_1",   out_result, 16'h1234);
        drive(1'b1, 16'h5678, 3'd2, 4'b0000, 1'b0);
        tick();
        check("bp_ready_2",  in_ready,   0);
        check("bp_valid_2",  out_valid,  1);
        drive(1'b1, 16'h9ABC, 3'd3, 4'b0000, 1'b0);
        tick();
        check("bp_hold_head",  out_result, 16'h1234);
        check("bp_hold_ready", in_ready,   0);
        out_ready = 1'b1;
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        tick();
        check("bp_pop1_ready", in_ready,   1);
        check("bp_pop2_head",  out_result, 16'h5678);
        check("bp_pop2_tag",   out_tag,    2);
        tick();
        check("bp_drained",    out_valid,  0);
        check("bp_z_kept",     flag_z,     1);

        // Flag gating
        drive(1'b1, 16'h8000, 3'd4, 4'b0010, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        tick();
        check("fg_n_gated", flag_n, 0);
        drive(1'b1, 16'h7FFF, 3'd6, 4'b0100, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        tick();
        check("fg_flags", {flag_c, flag_v, flag_n, flag_z}, 4'b0100);

        // Flush with two buffered entries that would set flag_c if popped
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 3'd1, 4'b1000, 1'b1);
        tick();
        drive(1'b1, 16'hBBBB, 3'd2, 4'b1000, 1'b1);
        tick();
        check("fl_full", in_ready, 0);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'hCCCC, 3'd3, 4'b1000, 1'b1);
        #1;
        check("fl_valid_masked", out_valid, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        check("fl_empty",   out_valid, 0);
        check("fl_ready",   in_ready,  1);
        check("fl_flags",   {flag_c, flag_v, flag_n, flag_z}, 4'b0100);
        drive(1'b1, 16'h4444, 3'd7, 4'b0000, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        check("fl_refill", out_result, 16'h4444);
        tick();
        check("fl_refill_pop", out_valid, 0);

        // Streaming at count 1
        drive(1'b1, 16'd1, 3'd1, 4'b0000, 1'b0);
        tick();
        for (int i = 2; i <= 8; i++) begin
            drive(1'b1, 16'(i), 3'(i), 4'b0000, 1'b0);
            check("st_valid",  out_valid,  1);
            check("st_result", out_result, i - 1);
            check("st_ready",  in_ready,   1);
            tick();
        end
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        check("st_last", out_result, 8);
        check("st_last_ready", in_ready, 1);
        tick();
        check("st_drained", out_valid, 0);

        // Async reset mid-cycle with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 3'd1, 4'b0000, 1'b0);
        tick();
        drive(1'b1, 16'h2222, 3'd2, 4'b0000, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        check("ar_pre_full", in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid",  out_valid,  0);
        check("ar_result", out_result, 0);
        check("ar_flags",  {flag_c, flag_v, flag_n, flag_z}, 0);
        check("ar_ready",  in_ready,   1);
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 16'h0BAD, 3'd3, 4'b0000, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 3'd0, 4'b0000, 1'b0);
        check("ar_refill", out_result, 16'h0BAD);
        check("ar_refill_valid", out_valid, 1);
        check("ar_refill_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
